// File: rtl/oumux_dat_feed_if.sv
// ---------------------------------------------------------------------------
// oumux_dat_feed_if
// Bundle of the source-side and mux-side signals of oumux_dat_feed.
//
// Parameter:
//   DEPTH        FIFO depth of the attached feed stage (sizes `level`)
//
// Signals (direction as seen by the feed stage, i.e. the `slave` modport):
//   s_dat        in   512  input data word
//   s_dest       in   4    destination kernel code (legal: 8, 9, 13, 14, 15)
//   s_valid      in   1    input word valid
//   s_ready      out  1    stage can accept a word
//   t_oumux_dat  out  512  head data word to the output mux
//   t_c_dat      out  4    head destination code (mux select)
//   t_valid      out  5    one-hot head valid {k15,k14,k13,k9,k8}
//   t_ready      in   5    per-destination ready, same bit order
//   level        out       current FIFO occupancy
//   bad_dest     out  1    pulse: illegal-destination word was dropped
//
// Handshake: a word moves on a rising clock edge exactly when its valid and
// the matching ready are both 1 in the cycle before that edge. On the input
// side that is s_valid & s_ready; on the output side it is any bit of
// t_valid & t_ready. Valid never waits on ready, and a source holding valid
// keeps its data stable until the transfer happens.
// ---------------------------------------------------------------------------
interface oumux_dat_feed_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [511:0]  s_dat;
  logic [3:0]    s_dest;
  logic          s_valid;
  logic          s_ready;
  logic [511:0]  t_oumux_dat;
  logic [3:0]    t_c_dat;
  logic [4:0]    t_valid;
  logic [4:0]    t_ready;
  logic [LW-1:0] level;
  logic          bad_dest;

  // Environment side: drives the producer inputs and the kernel readies.
  modport master (
    output s_dat, s_dest, s_valid, t_ready,
    input  s_ready, t_oumux_dat, t_c_dat, t_valid, level, bad_dest
  );

  // Feed stage side.
  modport slave (
    input  s_dat, s_dest, s_valid, t_ready,
    output s_ready, t_oumux_dat, t_c_dat, t_valid, level, bad_dest
  );
endinterface

// File: rtl/oumux_dat_feed.sv
// ---------------------------------------------------------------------------
// oumux_dat_feed
// Buffered source stage ahead of the output data mux. Words tagged with a
// destination kernel code are queued in a DEPTH-entry FIFO; the head word is
// presented with a one-hot valid for its kernel (k8, k9, k13, k14, k15) and
// popped when that kernel is ready. Words with an illegal code are accepted
// and discarded, raising a one-cycle bad_dest pulse.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   bus       slave modport of oumux_dat_feed_if (s_*, t_*, level, bad_dest)
//   drop_cnt  out  16-bit saturating dropped-word count
//                  (present only when OUMUX_FEED_DROPCNT_EN is defined)
//
// Optional feature macro: OUMUX_FEED_DROPCNT_EN
// ---------------------------------------------------------------------------
module oumux_dat_feed #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  oumux_dat_feed_if.slave   bus
`ifdef OUMUX_FEED_DROPCNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Storage is deliberately not reset; pointers and level define validity.
  logic [511:0]  r_mem_dat  [DEPTH];
  logic [3:0]    r_mem_dest [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_bad;

  logic          w_s_ready;
  logic          w_legal;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_nonempty;
  logic [3:0]    w_head_dest;
  logic [4:0]    w_onehot;
  logic [4:0]    w_t_valid;

  // Full flag comes from registered level only: a pop in the same cycle
  // does not open a slot for the incoming word.
  assign w_s_ready  = (r_level != LVL_FULL);
  assign w_nonempty = (r_level != '0);

  always_comb begin
    w_legal = 1'b0;
    case (bus.s_dest)
      4'd8, 4'd9, 4'd13, 4'd14, 4'd15: w_legal = 1'b1;
      default:                         w_legal = 1'b0;
    endcase
  end

  assign w_push = bus.s_valid & w_s_ready & w_legal;
  assign w_drop = bus.s_valid & w_s_ready & ~w_legal;

  assign w_head_dest = r_mem_dest[r_rptr];

  always_comb begin
    w_onehot = 5'b00000;
    case (w_head_dest)
      4'd8:    w_onehot = 5'b00001;
      4'd9:    w_onehot = 5'b00010;
      4'd13:   w_onehot = 5'b00100;
      4'd14:   w_onehot = 5'b01000;
      4'd15:   w_onehot = 5'b10000;
      default: w_onehot = 5'b00000;
    endcase
  end

  assign w_t_valid = w_nonempty ? w_onehot : 5'b00000;
  // Only the addressed kernel's ready bit can pop the head.
  assign w_pop     = |(w_t_valid & bus.t_ready);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dat[r_wptr]  <= bus.s_dat;
      r_mem_dest[r_wptr] <= bus.s_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_bad   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      r_bad <= w_drop;
    end
  end

`ifdef OUMUX_FEED_DROPCNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign bus.s_ready     = w_s_ready;
  assign bus.t_valid     = w_t_valid;
  assign bus.t_oumux_dat = w_nonempty ? r_mem_dat[r_rptr] : '0;
  assign bus.t_c_dat     = w_nonempty ? w_head_dest : 4'd0;
  assign bus.level       = r_level;
  assign bus.bad_dest    = r_bad;

endmodule

// File: tb/tb_oumux_dat_feed.sv
module tb_oumux_dat_feed;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oumux_dat_feed_if #(.DEPTH(DEPTH)) bus ();

`ifdef OUMUX_FEED_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  oumux_dat_feed #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef OUMUX_FEED_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // ---------------- reference model ----------------
  // Queue holds {dest, dat} of every accepted legal word, head at index 0.
  logic [515:0] exp_q[$];
  logic         exp_bad;
  logic [15:0]  exp_drop;
  int           checks = 0;
  int           errors = 0;

  int legal_codes [5] = '{8, 9, 13, 14, 15};

  // Kernel slot of a destination code, -1 when the code is not a kernel.
  function automatic int dest_idx(input logic [3:0] d);
    for (int i = 0; i < 5; i++)
      if (int'(d) == legal_codes[i]) return i;
    return -1;
  endfunction

  function automatic logic [511:0] rand_dat();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [3:0] d,
                       input logic [511:0] dat, input logic [4:0] rdy);
    bus.s_valid = v;
    bus.s_dest  = d;
    bus.s_dat   = dat;
    bus.t_ready = rdy;
  endtask

  // Advance the model by one clock edge using the inputs currently driven,
  // then let the DUT take the same edge. Returns at the following negedge.
  task automatic tick();
    bit acc;
    bit pop;
    bit legal;
    if (reset) begin
      exp_q.delete();
      exp_bad  = 1'b0;
      exp_drop = 16'd0;
    end else begin
      acc   = bus.s_valid && (exp_q.size() < DEPTH);
      pop   = (exp_q.size() > 0) && bus.t_ready[dest_idx(exp_q[0][515:512])];
      legal = dest_idx(bus.s_dest) >= 0;
      if (pop) void'(exp_q.pop_front());
      if (acc && legal) exp_q.push_back({bus.s_dest, bus.s_dat});
      exp_bad = acc && !legal;
      if (acc && !legal && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [515:0] obs,
                     input logic [515:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [511:0] e_dat;
    logic [3:0]   e_dest;
    logic [4:0]   e_valid;
    e_dat = '0; e_dest = '0; e_valid = '0;
    if (exp_q.size() > 0) begin
      e_dest  = exp_q[0][515:512];
      e_dat   = exp_q[0][511:0];
      e_valid = 5'(1 << dest_idx(e_dest));
    end
    chk({tag, ".level"},   516'(bus.level),       516'(exp_q.size()));
    chk({tag, ".s_ready"}, 516'(bus.s_ready),     516'(exp_q.size() != DEPTH));
    chk({tag, ".t_valid"}, 516'(bus.t_valid),     516'(e_valid));
    chk({tag, ".t_c_dat"}, 516'(bus.t_c_dat),     516'(e_dest));
    chk({tag, ".t_dat"},   516'(bus.t_oumux_dat), 516'(e_dat));
    chk({tag, ".bad"},     516'(bus.bad_dest),    516'(exp_bad));
`ifdef OUMUX_FEED_DROPCNT_EN
    chk({tag, ".drop"},    516'(drop_cnt),        516'(exp_drop));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [511:0] a5;
    logic [3:0]   d;
    a5 = {64{8'hA5}};
    reset = 1'b1;
    drive(1'b0, 4'd0, '0, 5'b00000);
    exp_bad = 1'b0; exp_drop = 16'd0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    check_all("reset");
    chk("reset.s_ready_const", 516'(bus.s_ready), 516'(1));

    // Single word to k9, held while unready, then popped.
    drive(1'b1, 4'd9, a5, 5'b00000); tick();
    drive(1'b0, 4'd0, '0, 5'b00000);
    check_all("k9_present");
    chk("k9_valid_const", 516'(bus.t_valid), 516'(5'b00010));
    tick(); check_all("k9_hold");
    chk("k9_dat_const", 516'(bus.t_oumux_dat), 516'(a5));
    bus.t_ready = 5'b00010; tick(); check_all("k9_pop");
    chk("k9_pop_level_const", 516'(bus.level), 516'(0));

    // Fill to DEPTH, 5th word refused, one pop reopens s_ready.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'(legal_codes[i % 5]), rand_dat(), 5'b00000); tick();
      check_all("fill");
    end
    chk("full_s_ready_const", 516'(bus.s_ready), 516'(0));
    drive(1'b1, 4'd8, rand_dat(), 5'b00000); tick(); check_all("fifth");
    drive(1'b0, 4'd0, '0, 5'b11111); tick(); check_all("one_pop");
    chk("one_pop_s_ready_const", 516'(bus.s_ready), 516'(1));
    for (int i = 0; i < DEPTH; i++) begin tick(); check_all("drain"); end

    // Illegal destination dropped with a one-cycle pulse.
    drive(1'b1, 4'd10, rand_dat(), 5'b00000); tick();
    drive(1'b0, 4'd0, '0, 5'b00000);
    check_all("bad10");
    chk("bad10_pulse_const", 516'(bus.bad_dest), 516'(1));
    tick(); check_all("bad10_clear");

    // Head k15 blocks k8 until k15 itself is ready.
    drive(1'b1, 4'd15, rand_dat(), 5'b01111); tick(); check_all("k15_push");
    drive(1'b1, 4'd8,  rand_dat(), 5'b01111); tick(); check_all("k8_push");
    drive(1'b0, 4'd0, '0, 5'b01111); tick(); check_all("k15_blocked");
    chk("k15_blocked_sel_const", 516'(bus.t_c_dat), 516'(15));
    bus.t_ready = 5'b10000; tick(); check_all("k15_pop");
    chk("k8_next_sel_const", 516'(bus.t_c_dat), 516'(8));
    bus.t_ready = 5'b00001; tick(); check_all("k8_pop");

    // Streaming, all ready: one word per cycle through the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'(legal_codes[i % 5]), rand_dat(), 5'b11111); tick();
      check_all("stream");
    end
    drive(1'b0, 4'd0, '0, 5'b11111); tick(); check_all("stream_end");

    // Reset with three words queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd13, rand_dat(), 5'b00000); tick();
    end
    check_all("pre_reset");
    chk("pre_reset_level_const", 516'(bus.level), 516'(3));
    drive(1'b1, 4'd14, rand_dat(), 5'b11111);
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b0, 4'd0, '0, 5'b00000);
    check_all("mid_reset");

    // Randomized traffic with occasional resets and illegal codes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7) d = 4'(legal_codes[$urandom_range(0, 4)]);
      else                          d = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), d, rand_dat(), 5'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      tick();
      reset = 1'b0;
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
